// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with a start/done handshake.
// Logic and arithmetic ops finish in one cycle; SLL/SRL shift one bit per cycle.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   Busy,
    output logic                   Done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   Error
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [3:0]             op_q;
    logic [DATA_WIDTH-1:0]  sreg;
    logic [SHAMT_WIDTH-1:0] count;

    logic [DATA_WIDTH-1:0]  calc_result;
    logic                   calc_error;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  sreg_next;

    // Single-cycle result, taken straight from the inputs on the accepting edge
    always_comb begin
        calc_result = '0;
        calc_error  = 1'b0;
        case (ALUOperation)
            OP_AND:  calc_result = A & B;
            OP_OR:   calc_result = A | B;
            OP_NOR:  calc_result = ~(A | B);
            OP_ADD:  calc_result = A + B;
            OP_SUB:  calc_result = A - B;
            OP_LUI:  calc_result = B << 16;
            OP_SLL:  calc_result = B << shamt;
            OP_SRL:  calc_result = B >> shamt;
            default: calc_error  = 1'b1;
        endcase
    end

    assign is_shift  = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign sreg_next = (op_q == OP_SLL) ? (sreg << 1) : (sreg >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            sreg      <= '0;
            count     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_q <= ALUOperation;
                        Busy <= 1'b1;
                        if (is_shift && (shamt != '0)) begin
                            state <= SHIFT;
                            count <= shamt;
                            sreg  <= B;
                        end else begin
                            state     <= DONE;
                            Done      <= 1'b1;
                            ALUResult <= calc_result;
                            Zero      <= (calc_result == '0);
                            Error     <= calc_error;
                        end
                    end
                end
                SHIFT: begin
                    sreg  <= sreg_next;
                    count <= count - 1'b1;
                    // count==1 means this edge performs the final shift
                    if (count == 1) begin
                        state     <= DONE;
                        Done      <= 1'b1;
                        ALUResult <= sreg_next;
                        Zero      <= (sreg_next == '0);
                        Error     <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
